// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the 32x32 register file,
// serves the ID read ports with write-first bypass, and keeps instret plus a one-cycle write trace.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf_wr_en,
    input  logic [1:0]       rf_wr_sel,
    input  logic [XLEN-1:0]  npc,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  mdr,
    input  logic [31:0]      ir,
    input  logic [4:0]       ra0,
    input  logic [4:0]       ra1,
    output logic [XLEN-1:0]  rd0,
    output logic [XLEN-1:0]  rd1,
    input  logic [4:0]       ra_dbg,
    output logic [XLEN-1:0]  rd_dbg,
    output logic [XLEN-1:0]  wb_data,
    output logic             trace_vld,
    output logic [4:0]       trace_addr,
    output logic [XLEN-1:0]  trace_data,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_NPC  = 2'b01,
        SEL_MDR  = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    logic [4:0]      wr_addr;
    logic            we;
    logic            retire;
    logic [XLEN-1:0] regs [NREG];

    assign wr_addr = ir[11:7];
    assign we      = rf_wr_en && (wr_addr != 5'd0);
    // Bubbles arrive as ir == 0; anything else retires, including stores and branches.
    assign retire  = (ir != 32'h0);

    always_comb begin
        // NOTE: wb_data gets a default before the case so every path assigns it and no latch is inferred.
        wb_data = '0;
        case (wb_sel_e'(rf_wr_sel))
            SEL_ALU:  wb_data = alu_out;
            SEL_NPC:  wb_data = npc;
            SEL_MDR:  wb_data = mdr;
            SEL_RSVD: wb_data = '0;
            default:  wb_data = '0;
        endcase
    end

    // NOTE: the array is cleared by reset because every register must read zero after reset,
    // which keeps it in flops rather than a RAM macro. Non-blocking assignments keep all
    // clocked processes order-independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wb_data;
        end
    end

    // x0 is never written (we excludes rd == 0), but the read side still forces zero
    // so the hardwired value never depends on array contents.
    always_comb begin
        rd0 = '0;
        if (ra0 == 5'd0) begin
            rd0 = '0;
        end else if (we && (ra0 == wr_addr)) begin
            rd0 = wb_data;
        end else begin
            rd0 = regs[ra0];
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (we && (ra1 == wr_addr)) begin
            rd1 = wb_data;
        end else begin
            rd1 = regs[ra1];
        end
    end

    // The debug port shows committed state only, so a debugger never sees a value that might not land.
    always_comb begin
        rd_dbg = '0;
        if (ra_dbg != 5'd0) begin
            rd_dbg = regs[ra_dbg];
        end
    end

    // Address and data are loaded every edge, so they stay deterministic even when trace_vld is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_vld  <= 1'b0;
            trace_addr <= '0;
            trace_data <= '0;
        end else begin
            trace_vld  <= we;
            trace_addr <= wr_addr;
            trace_data <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, source select, bypass, x0, trace, instret and async reset.
// A second instance built with CNT_W=4 exercises counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        rst_s;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_sel;
    logic [31:0] npc, alu_out, mdr, ir;
    logic [4:0]  ra0, ra1, ra_dbg;
    logic [31:0] rd0, rd1, rd_dbg, wb_data, trace_data;
    logic        trace_vld;
    logic [4:0]  trace_addr;
    logic [63:0] instret;

    logic [31:0] rd0_s, rd1_s, rd_dbg_s, wb_data_s, trace_data_s;
    logic        trace_vld_s;
    logic [4:0]  trace_addr_s;
    logic [3:0]  instret_s;

    int          vectors;
    int          miscompares;
    logic [63:0] exp_instret;

    wb_regfile dut (
        .clk(clk), .rst(rst), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
        .npc(npc), .alu_out(alu_out), .mdr(mdr), .ir(ir),
        .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
        .ra_dbg(ra_dbg), .rd_dbg(rd_dbg), .wb_data(wb_data),
        .trace_vld(trace_vld), .trace_addr(trace_addr), .trace_data(trace_data),
        .instret(instret)
    );

    wb_regfile #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst_s), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
        .npc(npc), .alu_out(alu_out), .mdr(mdr), .ir(ir),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_s), .rd1(rd1_s),
        .ra_dbg(ra_dbg), .rd_dbg(rd_dbg_s), .wb_data(wb_data_s),
        .trace_vld(trace_vld_s), .trace_addr(trace_addr_s), .trace_data(trace_data_s),
        .instret(instret_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] rd);
        return {20'h00000, rd, 7'b0110011};
    endfunction

    task automatic drive(input logic en, input logic [1:0] sel, input logic [31:0] irv,
                         input logic [31:0] a, input logic [31:0] n, input logic [31:0] m);
        rf_wr_en  = en;
        rf_wr_sel = sel;
        ir        = irv;
        alu_out   = a;
        npc       = n;
        mdr       = m;
    endtask

    task automatic bubble();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // One rising edge; outputs are sampled 1 time unit later, away from the edge.
    task automatic tick();
        if (ir != 32'h0) exp_instret = exp_instret + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_s = 1'b1;
        bubble();
        ra0 = '0; ra1 = '0; ra_dbg = '0;
        exp_instret = '0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0; rst_s = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a); ra1 = 5'(a); ra_dbg = 5'(a);
            #1;
            vectors++;
            if (rd0 !== 32'h0) begin miscompares++; $display("FAIL reset_rd0[%0d]: got %h want 0", a, rd0); end
            vectors++;
            if (rd1 !== 32'h0) begin miscompares++; $display("FAIL reset_rd1[%0d]: got %h want 0", a, rd1); end
            vectors++;
            if (rd_dbg !== 32'h0) begin miscompares++; $display("FAIL reset_rd_dbg[%0d]: got %h want 0", a, rd_dbg); end
        end
        vectors++;
        if (instret !== 64'h0) begin miscompares++; $display("FAIL reset_instret: got %h want 0", instret); end
        vectors++;
        if (trace_vld !== 1'b0) begin miscompares++; $display("FAIL reset_trace_vld: got %b want 0", trace_vld); end
        vectors++;
        if (trace_data !== 32'h0 || trace_addr !== 5'h0) begin
            miscompares++; $display("FAIL reset_trace: got addr %h data %h want 0/0", trace_addr, trace_data);
        end
    endtask

    task automatic test_bypass();
        @(posedge clk); #1;
        drive(1'b1, 2'b00, mk_ir(5'd5), 32'h12345678, 32'h0, 32'h0);
        ra0 = 5'd5; ra_dbg = 5'd5;
        #1;
        vectors++;
        if (wb_data !== 32'h12345678) begin miscompares++; $display("FAIL bypass_wb_data: got %h want 12345678", wb_data); end
        vectors++;
        if (rd0 !== 32'h12345678) begin miscompares++; $display("FAIL bypass_rd0: got %h want 12345678", rd0); end
        vectors++;
        if (rd_dbg !== 32'h0) begin miscompares++; $display("FAIL bypass_rd_dbg_pre: got %h want 0", rd_dbg); end
        tick();
        bubble();
        #1;
        vectors++;
        if (rd_dbg !== 32'h12345678) begin miscompares++; $display("FAIL bypass_rd_dbg_post: got %h want 12345678", rd_dbg); end
        vectors++;
        if (trace_vld !== 1'b1 || trace_addr !== 5'd5 || trace_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_trace: got vld %b addr %0d data %h want 1/5/12345678", trace_vld, trace_addr, trace_data);
        end
        vectors++;
        if (instret !== 64'd1) begin miscompares++; $display("FAIL bypass_instret: got %0d want 1", instret); end
    endtask

    task automatic test_sources();
        drive(1'b1, 2'b01, mk_ir(5'd1), 32'hAAAA0001, 32'h00003008, 32'hBBBB0001);
        tick();
        drive(1'b1, 2'b10, mk_ir(5'd2), 32'hAAAA0002, 32'hCCCC0002, 32'hFFFFFF80);
        tick();
        drive(1'b1, 2'b00, mk_ir(5'd3), 32'h00000055, 32'h0, 32'h0);
        tick();
        drive(1'b1, 2'b11, mk_ir(5'd3), 32'hDEADBEEF, 32'h11112222, 32'h33334444);
        #1;
        vectors++;
        if (wb_data !== 32'h0) begin miscompares++; $display("FAIL sel11_wb_data: got %h want 0", wb_data); end
        tick();
        bubble();
        ra0 = 5'd1; ra1 = 5'd2; ra_dbg = 5'd3;
        #1;
        vectors++;
        if (rd0 !== 32'h00003008) begin miscompares++; $display("FAIL sel01_x1: got %h want 00003008", rd0); end
        vectors++;
        if (rd1 !== 32'hFFFFFF80) begin miscompares++; $display("FAIL sel10_x2: got %h want ffffff80", rd1); end
        vectors++;
        if (rd_dbg !== 32'h0) begin miscompares++; $display("FAIL sel11_x3: got %h want 0", rd_dbg); end
        vectors++;
        if (trace_vld !== 1'b1 || trace_addr !== 5'd3 || trace_data !== 32'h0) begin
            miscompares++;
            $display("FAIL sel11_trace: got vld %b addr %0d data %h want 1/3/0", trace_vld, trace_addr, trace_data);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 2'b00, 32'h00000013, 32'hDEADBEEF, 32'h0, 32'h0);
        ra0 = 5'd0; ra1 = 5'd0; ra_dbg = 5'd0;
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL x0_rd0: got %h want 0", rd0); end
        vectors++;
        if (rd1 !== 32'h0) begin miscompares++; $display("FAIL x0_rd1: got %h want 0", rd1); end
        tick();
        bubble();
        #1;
        vectors++;
        if (rd_dbg !== 32'h0) begin miscompares++; $display("FAIL x0_rd_dbg: got %h want 0", rd_dbg); end
        vectors++;
        if (trace_vld !== 1'b0) begin miscompares++; $display("FAIL x0_trace_vld: got %b want 0", trace_vld); end
        vectors++;
        if (instret !== 64'd6) begin miscompares++; $display("FAIL x0_instret: got %0d want 6", instret); end
    endtask

    task automatic test_dual_port();
        drive(1'b1, 2'b00, mk_ir(5'd8), 32'h11111111, 32'h0, 32'h0);
        tick();
        drive(1'b1, 2'b00, mk_ir(5'd9), 32'h22222222, 32'h0, 32'h0);
        ra0 = 5'd9; ra1 = 5'd9; ra_dbg = 5'd9;
        #1;
        vectors++;
        if (rd0 !== 32'h22222222 || rd1 !== 32'h22222222) begin
            miscompares++; $display("FAIL dual_same_bypass: got %h/%h want 22222222/22222222", rd0, rd1);
        end
        ra1 = 5'd8;
        #1;
        vectors++;
        if (rd0 !== 32'h22222222 || rd1 !== 32'h11111111) begin
            miscompares++; $display("FAIL dual_mixed: got %h/%h want 22222222/11111111", rd0, rd1);
        end
        rf_wr_en = 1'b0;
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL nobypass_when_we0: got %h want 0", rd0); end
        tick();
        bubble();
        #1;
        vectors++;
        if (rd_dbg !== 32'h0 || trace_vld !== 1'b0) begin
            miscompares++; $display("FAIL no_commit_we0: got x9 %h vld %b want 0/0", rd_dbg, trace_vld);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b00, mk_ir(5'd10), 32'h00000001, 32'h0, 32'h0);
        tick();
        drive(1'b1, 2'b10, mk_ir(5'd10), 32'h0, 32'h0, 32'h00000002);
        ra0 = 5'd10; ra_dbg = 5'd10;
        #1;
        vectors++;
        if (rd0 !== 32'h00000002) begin miscompares++; $display("FAIL b2b_bypass: got %h want 2", rd0); end
        vectors++;
        if (rd_dbg !== 32'h00000001) begin miscompares++; $display("FAIL b2b_committed: got %h want 1", rd_dbg); end
        tick();
        bubble();
        #1;
        vectors++;
        if (rd_dbg !== 32'h00000002 || trace_data !== 32'h00000002 || trace_addr !== 5'd10) begin
            miscompares++;
            $display("FAIL b2b_post: got x10 %h trace %0d/%h want 2, 10/2", rd_dbg, trace_addr, trace_data);
        end
    endtask

    task automatic test_instret_seq();
        logic [63:0] base;
        logic [31:0] seq_ir [14];
        logic        seq_en [14];
        base = exp_instret;
        seq_ir = '{mk_ir(5'd11), 32'h0, mk_ir(5'd12), 32'h00112023, 32'h0, mk_ir(5'd13), mk_ir(5'd14),
                   32'h0, 32'h00212223, mk_ir(5'd15), mk_ir(5'd16), 32'h0, mk_ir(5'd17), mk_ir(5'd18)};
        seq_en = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 14; i++) begin
            drive(seq_en[i], 2'b00, seq_ir[i], 32'h100 + 32'(i), 32'h0, 32'h0);
            tick();
        end
        bubble();
        #1;
        vectors++;
        if (instret !== base + 64'd10) begin miscompares++; $display("FAIL instret_seq: got %0d want %0d", instret, base + 64'd10); end
        ra_dbg = 5'd18;
        #1;
        vectors++;
        if (rd_dbg !== 32'h0000010D) begin miscompares++; $display("FAIL seq_x18: got %h want 0000010d", rd_dbg); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst_s = 1'b1;
        #1;
        vectors++;
        if (instret_s !== 4'd0) begin miscompares++; $display("FAIL wrap_reset: got %0d want 0", instret_s); end
        rst_s = 1'b0;
        drive(1'b0, 2'b00, 32'h00000013, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        vectors++;
        if (instret_s !== 4'd15) begin miscompares++; $display("FAIL wrap_15: got %0d want 15", instret_s); end
        tick();
        vectors++;
        if (instret_s !== 4'd0) begin miscompares++; $display("FAIL wrap_16: got %0d want 0", instret_s); end
        tick();
        vectors++;
        if (instret_s !== 4'd1) begin miscompares++; $display("FAIL wrap_17: got %0d want 1", instret_s); end
        bubble();
        #1;
        vectors++;
        if (instret !== exp_instret) begin miscompares++; $display("FAIL instret_track: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b00, mk_ir(5'd7), 32'hA5A5A5A5, 32'h0, 32'h0);
        tick();
        bubble();
        ra_dbg = 5'd7; ra0 = 5'd7;
        #1;
        vectors++;
        if (rd_dbg !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL areset_pre_x7: got %h want a5a5a5a5", rd_dbg); end
        rst = 1'b1;
        #1;
        vectors++;
        if (rd_dbg !== 32'h0 || rd0 !== 32'h0) begin
            miscompares++; $display("FAIL areset_x7: got dbg %h rd0 %h want 0/0", rd_dbg, rd0);
        end
        vectors++;
        if (instret !== 64'h0) begin miscompares++; $display("FAIL areset_instret: got %0d want 0", instret); end
        vectors++;
        if (trace_vld !== 1'b0 || trace_data !== 32'h0) begin
            miscompares++; $display("FAIL areset_trace: got vld %b data %h want 0/0", trace_vld, trace_data);
        end
        rst = 1'b0;
        exp_instret = '0;
        drive(1'b1, 2'b00, mk_ir(5'd7), 32'h0000005A, 32'h0, 32'h0);
        tick();
        bubble();
        #1;
        vectors++;
        if (rd_dbg !== 32'h0000005A || instret !== 64'd1) begin
            miscompares++; $display("FAIL post_reset_commit: got x7 %h instret %0d want 5a/1", rd_dbg, instret);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_bypass();
        test_sources();
        test_x0();
        test_dual_port();
        test_back_to_back();
        test_instret_seq();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
